pointer_resolver: RTL and testbench

POINTER_RESOLVER -- requirements
Module: pointer_resolver

---
 rtl/pointer_resolver.sv | 139 +++++++++++++
 tb/tb_pointer_resolver.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/pointer_resolver.sv
// rtl/pointer_resolver.sv - resolves (label id, offset) pointers to data addresses through a label table
// Optional range check on offset vs. element count: define PRESOLVE_BOUNDS_CHECK_EN.
module pointer_resolver #(
    parameter int LT_AW = 6
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req,
    input  logic [11:0]      lbid,
    input  logic [15:0]      ofs,
    output logic             busy,
    output logic             done,
    output logic [15:0]      addr,
    output logic             fault,
    output logic [1:0]       fault_code,
    input  logic             lt_we,
    input  logic [LT_AW-1:0] lt_idx,
    input  logic             lt_valid,
    input  logic [15:0]      lt_base,
    input  logic [15:0]      lt_count
);

    localparam int DEPTH = 1 << LT_AW;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOOKUP = 2'd1,
        CHECK  = 2'd2,
        DONE   = 2'd3
    } state_t;

    state_t r_state;
    state_t w_next;

    logic [DEPTH-1:0] r_valid;
    logic [15:0]      r_base  [DEPTH];
    logic [15:0]      r_count [DEPTH];

    logic [11:0] r_lbid;
    logic [15:0] r_ofs;
    logic        r_e_valid;
    logic [15:0] r_e_base;
    logic [15:0] r_e_count;

    logic [15:0] r_addr;
    logic        r_fault;
    logic [1:0]  r_code;

    logic [15:0] w_sum;
    logic [1:0]  w_code;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (req) w_next = LOOKUP;
            LOOKUP:  w_next = CHECK;
            CHECK:   w_next = DONE;
            DONE:    w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    // Valid bits are cleared by reset; base/count deliberately keep their contents.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_valid <= '0;
        end else if (lt_we) begin
            r_valid[lt_idx] <= lt_valid;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset && lt_we) begin
            r_base[lt_idx]  <= lt_base;
            r_count[lt_idx] <= lt_count;
        end
    end

    // A write landing on the LOOKUP edge is not visible here: the old entry is latched.
    always_ff @(posedge clk) begin
        if (!reset) begin
            if (r_state == IDLE && req) begin
                r_lbid <= lbid;
                r_ofs  <= ofs;
            end
            if (r_state == LOOKUP) begin
                r_e_valid <= r_valid[r_lbid[LT_AW-1:0]];
                r_e_base  <= r_base[r_lbid[LT_AW-1:0]];
                r_e_count <= r_count[r_lbid[LT_AW-1:0]];
            end
        end
    end

    always_comb begin
        w_sum  = r_e_base + r_ofs;
        w_code = 2'd0;
        if (|r_lbid[11:LT_AW]) begin
            w_code = 2'd3;
        end else if (!r_e_valid) begin
            w_code = 2'd1;
`ifdef PRESOLVE_BOUNDS_CHECK_EN
        end else if (r_ofs >= r_e_count) begin
            w_code = 2'd2;
`endif
        end
    end

`ifndef PRESOLVE_BOUNDS_CHECK_EN
    logic w_unused_count;
    assign w_unused_count = ^r_e_count;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            r_addr  <= '0;
            r_fault <= 1'b0;
            r_code  <= 2'd0;
        end else if (r_state == CHECK) begin
            r_addr  <= (w_code == 2'd0) ? w_sum : 16'h0000;
            r_fault <= (w_code != 2'd0);
            r_code  <= w_code;
        end
    end

    assign busy       = (r_state != IDLE);
    assign done       = (r_state == DONE);
    assign addr       = r_addr;
    assign fault      = r_fault;
    assign fault_code = r_code;

endmodule

// File: tb/tb_pointer_resolver.sv
// tb/tb_pointer_resolver.sv - randomized and directed self-checking bench for pointer_resolver
module tb_pointer_resolver;

    localparam int LT_AW = 6;
    localparam int DEPTH = 1 << LT_AW;

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic             req = 1'b0;
    logic [11:0]      lbid = '0;
    logic [15:0]      ofs = '0;
    logic             busy, done, fault;
    logic [15:0]      addr;
    logic [1:0]       fault_code;
    logic             lt_we = 1'b0;
    logic [LT_AW-1:0] lt_idx = '0;
    logic             lt_valid = 1'b0;
    logic [15:0]      lt_base = '0;
    logic [15:0]      lt_count = '0;

    int n_checks = 0;
    int n_errors = 0;

    pointer_resolver #(.LT_AW(LT_AW)) dut (
        .clk(clk), .reset(reset), .req(req), .lbid(lbid), .ofs(ofs),
        .busy(busy), .done(done), .addr(addr), .fault(fault), .fault_code(fault_code),
        .lt_we(lt_we), .lt_idx(lt_idx), .lt_valid(lt_valid),
        .lt_base(lt_base), .lt_count(lt_count)
    );

    always #5 clk = ~clk;

    // Reference model: table contents plus "edges since acceptance" of the single outstanding request.
    bit      m_valid [DEPTH];
    int      m_base  [DEPTH];
    int      m_count [DEPTH];
    int      m_age = -1;
    int      m_lbid, m_ofs;
    bit      s_valid;
    int      s_base, s_count;
    int      e_addr = 0, e_fault = 0, e_code = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic void resolve();
        int code;
        code = 0;
        if ((m_lbid >> LT_AW) != 0) code = 3;
        else if (!s_valid) code = 1;
`ifdef PRESOLVE_BOUNDS_CHECK_EN
        else if (m_ofs >= s_count) code = 2;
`endif
        e_code  = code;
        e_fault = (code != 0);
        e_addr  = (code == 0) ? ((s_base + m_ofs) % 65536) : 0;
    endfunction

    task automatic tick();
        @(posedge clk);
        if (reset) begin
            m_age = -1;
            foreach (m_valid[i]) m_valid[i] = 1'b0;
            e_addr = 0; e_fault = 0; e_code = 0;
        end else begin
            if (m_age == -1) begin
                if (req) begin
                    m_lbid = lbid; m_ofs = ofs; m_age = 1;
                end
            end else if (m_age == 1) begin
                s_valid = m_valid[m_lbid % DEPTH];
                s_base  = m_base[m_lbid % DEPTH];
                s_count = m_count[m_lbid % DEPTH];
                m_age = 2;
            end else if (m_age == 2) begin
                resolve();
                m_age = 3;
            end else begin
                m_age = -1;
            end
            if (lt_we) begin
                m_valid[lt_idx] = lt_valid;
                m_base[lt_idx]  = lt_base;
                m_count[lt_idx] = lt_count;
            end
        end
        #1;
        check("busy", busy, m_age != -1);
        check("done", done, m_age == 3);
        check("addr", addr, e_addr);
        check("fault", fault, e_fault);
        check("fault_code", fault_code, e_code);
    endtask

    task automatic do_write(input int idx, input bit v, input int b, input int c);
        lt_we = 1'b1; lt_idx = idx; lt_valid = v; lt_base = b; lt_count = c;
        tick();
        lt_we = 1'b0;
    endtask

    task automatic do_req(input int lb, input int o);
        req = 1'b1; lbid = lb; ofs = o;
        tick();
        req = 1'b0;
    endtask

    task automatic wait_done(output int lat);
        lat = 0;
        do begin
            tick();
            lat++;
        end while (!done && lat < 10);
        check("done_seen", done, 1'b1);
    endtask

    int lat;
    int ndone;
    logic [15:0] got_addr;

    initial begin
        tick();
        tick();
        check("rst_busy", busy, 1'b0);
        check("rst_addr", addr, 16'h0000);
        reset = 1'b0;
        tick();

        do_write(5, 1'b1, 16'h1000, 16'h0020);
        do_req(5, 16'h001F);
        wait_done(lat);
        check("latency", lat, 2);
        check("d031_addr", addr, 16'h101F);
        check("d031_fault", fault, 1'b0);
        tick();

        do_req(5, 16'h0020);
        wait_done(lat);
`ifdef PRESOLVE_BOUNDS_CHECK_EN
        check("d032_code", fault_code, 2'd2);
        check("d032_addr", addr, 16'h0000);
`else
        check("d032_fault", fault, 1'b0);
        check("d032_addr", addr, 16'h1020);
`endif
        tick();

        do_req(12'h040, 0);
        wait_done(lat);
        check("d033_beyond", fault_code, 2'd3);
        tick();
        do_req(7, 0);
        wait_done(lat);
        check("d033_invalid", fault_code, 2'd1);
        tick();
        do_write(9, 1'b1, 16'hFFF0, 16'h0100);
        do_req(9, 16'h0020);
        wait_done(lat);
        check("d033_wrap", addr, 16'h0010);
        check("d033_wrapf", fault, 1'b0);
        tick();

        // Second req during LOOKUP is ignored; the same-edge table write is not seen.
        do_req(5, 16'h0001);
        req = 1'b1; lbid = 5; ofs = 16'h0002;
        lt_we = 1'b1; lt_idx = 5; lt_valid = 1'b1; lt_base = 16'h2000; lt_count = 16'h0020;
        tick();
        req = 1'b0; lt_we = 1'b0;
        ndone = 0; got_addr = '0;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (done) begin
                ndone++;
                got_addr = addr;
            end
        end
        check("d034_ndone", ndone, 1);
        check("d034_old", got_addr, 16'h1001);
        do_req(5, 16'h0003);
        wait_done(lat);
        check("d034_new", addr, 16'h2003);
        tick();

        do_req(5, 16'h0004);
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("d035_busy", busy, 1'b0);
        check("d035_done", done, 1'b0);
        check("d035_addr", addr, 16'h0000);
        for (int i = 0; i < 4; i++) begin
            tick();
            check("d035_nodone", done, 1'b0);
        end
        do_req(5, 0);
        wait_done(lat);
        check("d035_code1", fault_code, 2'd1);
        tick();

        for (int i = 0; i < 600; i++) begin
            req   = ($urandom_range(0, 2) == 0);
            lbid  = ($urandom_range(0, 9) == 0) ? 12'($urandom) : 12'($urandom_range(0, 7));
            ofs   = ($urandom_range(0, 1) == 0) ? 16'($urandom_range(0, 64)) : 16'($urandom);
            lt_we = ($urandom_range(0, 3) == 0);
            lt_idx   = LT_AW'($urandom_range(0, 7));
            lt_valid = ($urandom_range(0, 3) != 0);
            lt_base  = 16'($urandom);
            lt_count = 16'($urandom_range(0, 64));
            reset = ($urandom_range(0, 59) == 0);
            tick();
        end
        reset = 1'b0; req = 1'b0; lt_we = 1'b0;
        tick();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
